// File: rtl/mem_inst_resp.sv
// rtl/mem_inst_resp.sv - instruction fetch responder assembling 32-bit words from a byte-wide RAM
module mem_inst_resp (
  input  logic        clk,
  input  logic        rst,
  input  logic        instEn,
  input  logic [31:0] instAddr,
  input  logic        instDiscard,
  output logic        memInstOutEn,
  output logic [31:0] memInst,
  output logic [31:0] ram_a,
  input  logic [7:0]  ram_din,
  output logic        fillEn,
  output logic [31:0] fillAddr,
  output logic [31:0] fillInst
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic [1:0]  byte_cnt;
  logic [1:0]  byte_next;
  logic [31:0] req_addr;
  logic [23:0] byte_buf;

  assign byte_next = byte_cnt + 2'd1;

  // Response strobes come straight from the Resp state; a discard in that
  // cycle masks them so an aborted word is never presented downstream.
  assign memInstOutEn = (state == RESP) && !instDiscard;
  assign fillEn       = (state == RESP) && !instDiscard;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a discard with instEn held restarts on the new address.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (instEn) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        if (instDiscard) begin
          if (instEn) begin
            accept     = 1'b1;
            state_next = READ;
          end else begin
            state_next = IDLE;
          end
        end else if (byte_cnt == 2'd3) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (instDiscard && instEn) begin
          accept     = 1'b1;
          state_next = READ;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address sequencing and byte assembly; the output word is only updated
  // when byte 3 lands, so partial or aborted bytes never become visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr <= 32'd0;
      ram_a    <= 32'd0;
      byte_cnt <= 2'd0;
      byte_buf <= 24'd0;
      memInst  <= 32'd0;
      fillInst <= 32'd0;
      fillAddr <= 32'd0;
    end else if (accept) begin
      req_addr <= instAddr;
      ram_a    <= instAddr;
      byte_cnt <= 2'd0;
    end else if (state == READ && !instDiscard) begin
      case (byte_cnt)
        2'd0: byte_buf[7:0]   <= ram_din;
        2'd1: byte_buf[15:8]  <= ram_din;
        2'd2: byte_buf[23:16] <= ram_din;
        default: begin
          memInst  <= {ram_din, byte_buf};
          fillInst <= {ram_din, byte_buf};
          fillAddr <= req_addr;
        end
      endcase
      if (byte_cnt != 2'd3) begin
        byte_cnt <= byte_next;
        ram_a    <= req_addr + {30'd0, byte_next};
      end
    end
  end

endmodule

// File: doc/mem_inst_resp.md
MEM_INST_RESP -- requirements
Module: mem_inst_resp

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 The block SHALL have: instEn  input  1  fetch request valid, held high by fetch until served.
REQ-003 The block SHALL have: instAddr  input  32  byte address of the requested instruction, word-aligned.
REQ-004 The block SHALL have: instDiscard  input  1  one-cycle pulse that aborts the transaction in flight.
REQ-005 The block SHALL have: memInstOutEn  output  1  one-cycle response-valid pulse, registered.
REQ-006 The block SHALL have: memInst  output  32  assembled instruction, registered, valid when memInstOutEn=1.
REQ-007 The block SHALL have: ram_a  output  32  byte address to RAM, registered.
REQ-008 The block SHALL have: ram_din  input  8  RAM read byte, valid one cycle after ram_a is presented.
REQ-009 The block SHALL have: fillEn  output  1  icache fill strobe, coincident with memInstOutEn.
REQ-010 The block SHALL have: fillAddr  output  32  icache fill address; fillInst  output  32  icache fill data.

Function
REQ-011 States SHALL be Idle, Read, and Resp.
REQ-012 In Idle, on an edge with instEn=1, the block SHALL latch instAddr into reqAddr, drive ram_a<=instAddr, clear the byte counter, and enter Read.
REQ-013 In Read, the block SHALL advance ram_a by 1 per cycle through reqAddr+3, then hold ram_a.
REQ-014 In Read, the block SHALL capture ram_din one cycle after each address, in byte order 0..3.
REQ-015 Byte k SHALL land in memInst[8k+7:8k] (little-endian).
REQ-016 After byte 3 is captured, the block SHALL enter Resp.
REQ-017 In Resp, memInstOutEn and fillEn SHALL be 1 for exactly one cycle, with fillAddr=reqAddr and fillInst=memInst.
REQ-018 The block SHALL return from Resp to Idle at the next edge.
REQ-019 Latency: memInstOutEn SHALL rise in the 5th cycle after the accepting edge; throughput SHALL be one instruction per 6 cycles.
REQ-020 Once a request is accepted, instEn and instAddr SHALL be ignored until Idle; deassertion of instEn SHALL NOT cancel the transaction.
REQ-021 Idle-to-accept: in the cycle after Resp, instEn/instAddr SHALL be sampled fresh, so a request updated at the Resp edge is served with its new address.
REQ-022 On instDiscard=1 in Read or Resp, the block SHALL suppress memInstOutEn and fillEn that cycle and drop partial bytes.
REQ-023 On that same instDiscard edge, if instEn=1, the block SHALL accept instAddr as a new request (restart Read at byte 0); otherwise it SHALL go to Idle.
REQ-024 In Idle, instDiscard=1 SHALL be treated as a plain request cycle per REQ-012.
REQ-025 RAM data returned for aborted addresses SHALL never reach memInst or fillInst.
REQ-026 Address arithmetic SHALL be 32-bit modulo: reqAddr=0xFFFFFFFC SHALL read 0xFFFFFFFC..0xFFFFFFFF with no wrap into the next word.
REQ-027 memInst SHALL hold its last value outside Resp; downstream SHALL qualify it with memInstOutEn.

Reset
REQ-028 On rst=1 at an edge, the block SHALL enter Idle and set memInstOutEn=0, fillEn=0, memInst=0, fillInst=0, fillAddr=0, ram_a=0, and the byte counter to 0.
REQ-029 Reset SHALL take priority over instEn and instDiscard.
REQ-030 Reset mid-Read SHALL abort the transaction with no response.

Verification
REQ-031 Basic read: RAM bytes 0x13,0x05,0x10,0x00 at 0x100..0x103; instEn=1, instAddr=0x100 -> single pulse memInstOutEn with memInst=0x00100513 5 cycles after accept; fillEn=1, fillAddr=0x100.
REQ-032 Back-to-back reads: instEn held, instAddr updated to 0x104 at the response edge -> second response is the word at 0x104, 6 cycles after the first; no duplicate of 0x100.
REQ-033 Discard mid-read: instDiscard=1 with instAddr=0x200 at byte 2 of 0x100 -> no response for 0x100; next pulse carries the word at 0x200.
REQ-034 Discard in Resp cycle: memInstOutEn=0 and fillEn=0 that cycle, and the new request starts at the following edge.
REQ-035 Stall tolerance: instEn dropped to 0 one cycle after accept -> response still delivered once, then Idle with ram_a stable.
REQ-036 Reset mid-Read: rst=1 at byte 1 -> all outputs 0 next cycle, no memInstOutEn; a fresh request afterward completes normally.
